// File: rtl/atctlc2axi500_onehot_queue.sv
// Circular request queue with rotating one-hot head/tail pointers.
// Parent selects the head entry with a one-hot AND-OR mux over entry_data.
module atctlc2axi500_onehot_queue #(
  parameter int DEPTH    = 4,
  parameter int W        = 8,
  parameter int CW       = 3,
  parameter int AFULL_TH = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               enq_valid,
  output logic               enq_ready,
  input  logic [W-1:0]       enq_data,
  output logic               deq_valid,
  input  logic               deq_ready,
  output logic [DEPTH-1:0]   head_ptr,
  output logic [DEPTH-1:0]   tail_ptr,
  output logic [DEPTH*W-1:0] entry_data,
  output logic [DEPTH-1:0]   entry_vld,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty,
  output logic               afull
);

  localparam logic [DEPTH-1:0] PTR_RST = DEPTH'(1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_AF  = CW'(AFULL_TH);

  logic [DEPTH-1:0]        head_q;
  logic [DEPTH-1:0]        tail_q;
  logic [DEPTH-1:0]        vld_q;
  logic [DEPTH-1:0][W-1:0] data_q;
  logic [CW-1:0]           cnt_q;

  logic enq_fire;
  logic deq_fire;
  logic enq_go;
  logic deq_go;

  function automatic logic [DEPTH-1:0] rotl(
    input logic [DEPTH-1:0] p
  );
    return {p[DEPTH-2:0], p[DEPTH-1]};
  endfunction

  // Handshakes come only from registered flags; flush masks both sides.
  always_comb begin
    full      = (cnt_q == CNT_MAX);
    empty     = (cnt_q == '0);
    afull     = (cnt_q >= CNT_AF);
    enq_ready = ~full;
    deq_valid = ~empty;
    enq_fire  = enq_valid & enq_ready;
    deq_fire  = deq_valid & deq_ready;
    enq_go    = enq_fire & ~flush;
    deq_go    = deq_fire & ~flush;
  end

  // Head/tail pointers rotate left one slot per accepted transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= PTR_RST;
      tail_q <= PTR_RST;
    end else if (flush) begin
      head_q <= PTR_RST;
      tail_q <= PTR_RST;
    end else begin
      if (enq_go) tail_q <= rotl(tail_q);
      if (deq_go) head_q <= rotl(head_q);
    end
  end

  // Per-entry occupied flags: set at tail on enq, cleared at head on deq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (deq_go && head_q[i]) vld_q[i] <= 1'b0;
        if (enq_go && tail_q[i]) vld_q[i] <= 1'b1;
      end
    end
  end

  // Storage written only at tail on an accepted enq; kept across deq/flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_go && tail_q[i]) data_q[i] <= enq_data;
      end
    end
  end

  // Occupancy count; simultaneous enq and deq leave it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      unique case ({enq_go, deq_go})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Output wiring of the registered state.
  always_comb begin
    head_ptr   = head_q;
    tail_ptr   = tail_q;
    entry_vld  = vld_q;
    entry_data = data_q;
    count      = cnt_q;
  end

  // Expected occupancy mask: the circular span from head of cnt_q slots.
  logic [DEPTH-1:0] span;
  int               hidx;
  always_comb begin
    hidx = 0;
    span = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (head_q[i]) hidx = i;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (((i - hidx + DEPTH) % DEPTH) < int'(cnt_q)) span[i] = 1'b1;
    end
  end

  a_head_onehot: assert property (
    @(posedge clk) disable iff (reset) $onehot(head_q));
  a_tail_onehot: assert property (
    @(posedge clk) disable iff (reset) $onehot(tail_q));
  a_ptr_eq: assert property (
    @(posedge clk) disable iff (reset)
    (head_q == tail_q) == (empty || full));
  a_full_vld: assert property (
    @(posedge clk) disable iff (reset) full == (&vld_q));
  a_empty_vld: assert property (
    @(posedge clk) disable iff (reset) empty == ~(|vld_q));
  a_span: assert property (
    @(posedge clk) disable iff (reset) vld_q == span);
  a_cnt_max: assert property (
    @(posedge clk) disable iff (reset) cnt_q <= CNT_MAX);

endmodule

// File: doc/atctlc2axi500_onehot_queue.md
Name: atctlc2axi500_onehot_queue

Overview:
- DEPTH-entry circular queue with rotating one-hot head and tail pointers.
- Holds request attributes (address, ID, etc.) between the bus slave capture logic and the request issue logic.
- Exports the flattened entry array and the one-hot head pointer. The parent selects the head entry with a one-hot AND-OR multiplexer (sel = head_ptr, in = entry_data).
- Also provides valid/ready enqueue and dequeue handshakes, occupancy count, full, empty, almost-full and flush.

Parameters:
- DEPTH, 4, number of entries; must be >= 2.
- W, 8, entry width in bits.
- CW, 3, count width; parent sets it to ceil(log2(DEPTH+1)).
- AFULL_TH, 3, afull asserts when count >= AFULL_TH; legal range 1..DEPTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all entries and pointers.
- enq_valid  input  1  enqueue request.
- enq_ready  output  1  queue can accept an entry; equals ~full.
- enq_data  input  W  entry written at tail.
- deq_valid  output  1  head entry valid; equals ~empty.
- deq_ready  input  1  consumer takes head entry.
- head_ptr  output  DEPTH  one-hot index of oldest entry.
- tail_ptr  output  DEPTH  one-hot index of next write slot.
- entry_data  output  DEPTH*W  flattened storage; entry i at [i*W +: W].
- entry_vld  output  DEPTH  per-entry occupied flag.
- count  output  CW  number of occupied entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- afull  output  1  count >= AFULL_TH.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset values:
  - head_ptr = tail_ptr = DEPTH'b1 (entry 0).
  - entry_vld = 0, entry_data = 0, count = 0.
  - empty = 1, full = 0, afull = 0, enq_ready = 1, deq_valid = 0.
- Handshakes:
  - enq fires = enq_valid & enq_ready.
  - deq fires = deq_valid & deq_ready.
  - enq_ready and deq_valid are pure functions of registered state; no combinational path from enq_valid or deq_ready.
- Enqueue:
  - On enq fire, entry_data at tail_ptr <= enq_data and entry_vld at tail_ptr <= 1.
  - tail_ptr rotates left by one; MSB wraps to bit 0.
- Dequeue:
  - On deq fire, entry_vld at head_ptr <= 0 and head_ptr rotates left by one with wrap.
  - entry_data is not cleared on dequeue.
- Latency:
  - An entry enqueued in cycle t is visible (deq_valid = 1, head selects it) in cycle t+1.
  - No same-cycle bypass when empty.
- Simultaneous enq and deq fire:
  - Both pointers advance; count is unchanged.
  - When not full and head != tail, distinct entries are written and cleared.
  - When full, enq_ready = 0, so no enq happens, even if deq fires in the same cycle.
- Count:
  - count += 1 on enq only; -= 1 on deq only; unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Flags:
  - full, empty and afull derive from registered count.
  - Equivalently, full = &entry_vld and empty = ~|entry_vld; these must always agree with count (assertion).
- Flush:
  - Has priority over enq and deq in the same cycle; both are ignored.
  - Next cycle: pointers = DEPTH'b1, entry_vld = 0, count = 0; entry_data retains contents.
- Invariants (checked by assertions every cycle out of reset):
  - head_ptr and tail_ptr each exactly one-hot.
  - head_ptr == tail_ptr iff count is 0 or DEPTH.
  - entry_vld equals the circular span from head up to, but excluding, tail, with count bits set.
- Reset mid-operation: asynchronous return to the reset values above; in-flight handshakes are lost and no entry is retained.
- X-safety: enq_data may be X when enq_valid = 0; storage must not update from it.

Test Plan:
- Reset then 4 enqueues of 0x11, 0x22, 0x33, 0x44 with deq_ready = 0:
  - count steps 1..4; tail_ptr 0010 -> 0100 -> 1000 -> 0001.
  - afull at count 3; full and enq_ready = 0 after the 4th.
  - A 5th enq_valid is held and not accepted.
- Drain the full queue with deq_ready = 1:
  - The parent's one-hot mux output is 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Then empty = 1, deq_valid = 0, head_ptr = 0001.
- Steady stream, enq and deq every cycle for 10 cycles starting at count = 1:
  - count stays 1; pointers wrap twice; data order preserved.
- Full queue with enq_valid = 1 and deq_ready = 1 in the same cycle:
  - Dequeue only; count 4 -> 3; enq accepted the next cycle.
- flush asserted with enq_valid and deq_ready high at count = 2:
  - Next cycle count = 0, pointers = 0001, entry_vld = 0; no write occurs.
- reset asserted asynchronously mid-stream at count = 3:
  - Outputs return to reset values before the next clk edge.
  - Traffic after release behaves as from power-up.
